// File: rtl/pid_balance_gen2_if.sv
// Sample/command inputs and motor drive outputs of the balance controller.
interface pid_balance_gen2_if #(
    parameter int unsigned OUT_W = 11
) ();
    logic               vld;
    logic signed [15:0] ptch;
    logic signed [11:0] ld_cell_diff;
    logic               rider_off;
    logic               en_steer;
    logic               pwr_up;
    logic [7:0]         p_coeff;
    logic [7:0]         d_coeff;
    logic [11:0]        min_duty;
    logic [OUT_W-1:0]   lft_spd;
    logic [OUT_W-1:0]   rght_spd;
    logic               lft_rev;
    logic               rght_rev;
    logic               out_vld;
    logic               too_fast;
    logic               fault;
    logic [1:0]         state;

    modport slave (
        input  vld, ptch, ld_cell_diff, rider_off, en_steer, pwr_up, p_coeff, d_coeff, min_duty,
        output lft_spd, rght_spd, lft_rev, rght_rev, out_vld, too_fast, fault, state
    );

    modport master (
        output vld, ptch, ld_cell_diff, rider_off, en_steer, pwr_up, p_coeff, d_coeff, min_duty,
        input  lft_spd, rght_spd, lft_rev, rght_rev, out_vld, too_fast, fault, state
    );
endinterface

// File: rtl/pid_balance_gen2.sv
// Self-balancing controller: 3-stage PID pipeline with soft-start ramp, steering,
// dead-zone/gain shaping and an over-speed fault FSM.
module pid_balance_gen2 #(
    parameter int unsigned ERR_W     = 10,
    parameter int unsigned D_DEPTH   = 2,
    parameter int unsigned I_SHIFT   = 6,
    parameter int unsigned OUT_W     = 11,
    parameter int unsigned RAMP_LOG2 = 6,
    parameter int          LOW_BAND  = 70,
    parameter int          GAIN_MULT = 15,
    parameter int          FAST_LIM  = 1536,
    parameter int unsigned FAULT_CNT = 4
) (
    input logic               clk,
    input logic               rst_n,
    pid_balance_gen2_if.slave bus
);
    localparam int unsigned PW = ERR_W + 9;
    localparam int unsigned DW = ERR_W + 6;
    localparam int unsigned IW = ERR_W + 8;
    localparam int unsigned FW = $clog2(FAULT_CNT + 1);
    localparam int EMAX    = (1 << (ERR_W - 1)) - 1;
    localparam int EMIN    = -EMAX - 1;
    localparam int DMAX    = (1 << (ERR_W - 4)) - 1;
    localparam int DMIN    = -DMAX - 1;
    localparam int IMAX    = (1 << (IW - 1)) - 1;
    localparam int IMIN    = -IMAX - 1;
    localparam int SMAX    = 32767;
    localparam int SMIN    = -32768;
    localparam int SPD_MAX = (1 << OUT_W) - 1;

    typedef enum logic [1:0] {StIdle = 2'd0, StRamp = 2'd1, StRun = 2'd2, StFault = 2'd3} state_e;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int shape(input int t, input int md);
        int r;
        if (((t < 0) ? -t : t) >= LOW_BAND) r = (t < 0) ? t - md : t + md;
        else r = t * GAIN_MULT;
        return clamp(r, SMIN, SMAX);
    endfunction

    function automatic int speed(input int s);
        int m;
        m = (s < 0) ? -s : s;
        return (m > SPD_MAX) ? SPD_MAX : m;
    endfunction

    state_e                  state_q, state_d;
    logic [RAMP_LOG2-1:0]    ramp_cnt_q, ramp_cnt_d;
    logic [FW-1:0]           fcnt_q, fcnt_d;
    logic signed [ERR_W-1:0] hist_q [D_DEPTH];
    logic signed [ERR_W-1:0] hist_d [D_DEPTH];
    logic signed [IW-1:0]    integ_q, integ_d;
    logic signed [PW-1:0]    p_q;
    logic signed [DW-1:0]    d_q;
    logic [11:0]             md1_q, md2_q;
    logic                    v1_q, v2_q;
    logic signed [15:0]      lt_q, rt_q;
    logic [OUT_W-1:0]        lspd_q, rspd_q, lspd_c, rspd_c;
    logic                    lrev_q, rrev_q, lrev_c, rrev_c;
    logic                    out_vld_q, too_fast_q, tf_c, mask_c, active_c;
    int err_c, p_c, d_c, isum_c, pid_c, sum_c, ldh_c, lt_c, rt_c, lsh_c, rsh_c;

    assign active_c = (state_q == StRamp) || (state_q == StRun);

    // Stage 1 arithmetic and integrator/history next state
    always_comb begin
        err_c  = clamp(int'(bus.ptch), EMIN, EMAX);
        p_c    = err_c * int'(bus.p_coeff);
        d_c    = clamp(err_c - int'(hist_q[D_DEPTH-1]), DMIN, DMAX) * int'(bus.d_coeff);
        isum_c = int'(integ_q) + err_c;

        integ_d = integ_q;
        if (!active_c) integ_d = '0;
        else if (bus.vld && isum_c <= IMAX && isum_c >= IMIN) integ_d = IW'(isum_c);

        hist_d = hist_q;
        if (state_q == StIdle) begin
            for (int i = 0; i < D_DEPTH; i++) hist_d[i] = '0;
        end else if (bus.vld) begin
            hist_d[0] = ERR_W'(err_c);
            for (int i = 1; i < D_DEPTH; i++) hist_d[i] = hist_q[i-1];
        end
    end

    // Stage 2: PID sum, soft-start scaling, steering split
    always_comb begin
        pid_c = clamp(int'(p_q) + int'(d_q) + int'(integ_q >>> I_SHIFT), SMIN, SMAX);
        sum_c = (state_q == StRamp) ? (pid_c * int'(ramp_cnt_q)) >>> RAMP_LOG2 : pid_c;
        ldh_c = int'(bus.ld_cell_diff) >>> 3;
        lt_c  = bus.en_steer ? clamp(sum_c - ldh_c, SMIN, SMAX) : sum_c;
        rt_c  = bus.en_steer ? clamp(sum_c + ldh_c, SMIN, SMAX) : sum_c;
    end

    // Stage 3: shaping, masking while not driving, over-speed flag
    always_comb begin
        lsh_c  = shape(int'(lt_q), int'(md2_q));
        rsh_c  = shape(int'(rt_q), int'(md2_q));
        mask_c = (state_q == StIdle) || (state_q == StFault);
        lspd_c = mask_c ? '0 : OUT_W'(speed(lsh_c));
        rspd_c = mask_c ? '0 : OUT_W'(speed(rsh_c));
        lrev_c = !mask_c && (lsh_c < 0);
        rrev_c = !mask_c && (rsh_c < 0);
        tf_c   = (int'(lspd_c) > FAST_LIM) || (int'(rspd_c) > FAST_LIM);
    end

    always_comb begin
        state_d = state_q;
        if (!bus.pwr_up) state_d = StIdle;
        else if (active_c && fcnt_q == FW'(FAULT_CNT)) state_d = StFault;
        else if (active_c && bus.rider_off) state_d = StIdle;
        else if (state_q == StIdle && !bus.rider_off) state_d = StRamp;
        else if (state_q == StRamp && bus.vld && ramp_cnt_q == '1) state_d = StRun;

        ramp_cnt_d = ramp_cnt_q;
        if (state_q != StRamp) ramp_cnt_d = '0;
        else if (bus.vld) ramp_cnt_d = ramp_cnt_q + 1'b1;

        fcnt_d = fcnt_q;
        if (!active_c) fcnt_d = '0;
        else if (out_vld_q && !too_fast_q) fcnt_d = '0;
        else if (out_vld_q && fcnt_q != FW'(FAULT_CNT)) fcnt_d = fcnt_q + FW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ramp_cnt_q <= '0;
            fcnt_q     <= '0;
            for (int i = 0; i < D_DEPTH; i++) hist_q[i] <= '0;
            integ_q    <= '0;
            p_q        <= '0;
            d_q        <= '0;
            md1_q      <= '0;
            md2_q      <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            lt_q       <= '0;
            rt_q       <= '0;
            lspd_q     <= '0;
            rspd_q     <= '0;
            lrev_q     <= 1'b0;
            rrev_q     <= 1'b0;
            out_vld_q  <= 1'b0;
            too_fast_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ramp_cnt_q <= ramp_cnt_d;
            fcnt_q     <= fcnt_d;
            hist_q     <= hist_d;
            integ_q    <= integ_d;
            v1_q       <= bus.vld;
            v2_q       <= v1_q;
            out_vld_q  <= v2_q;
            if (bus.vld) begin
                p_q   <= PW'(p_c);
                d_q   <= DW'(d_c);
                md1_q <= bus.min_duty;
            end
            if (v1_q) begin
                lt_q  <= 16'(lt_c);
                rt_q  <= 16'(rt_c);
                md2_q <= md1_q;
            end
            if (v2_q) begin
                lspd_q     <= lspd_c;
                rspd_q     <= rspd_c;
                lrev_q     <= lrev_c;
                rrev_q     <= rrev_c;
                too_fast_q <= tf_c;
            end
        end
    end

    assign bus.lft_spd  = lspd_q;
    assign bus.rght_spd = rspd_q;
    assign bus.lft_rev  = lrev_q;
    assign bus.rght_rev = rrev_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.too_fast = too_fast_q;
    assign bus.fault    = (state_q == StFault);
    assign bus.state    = state_q;
endmodule

// File: tb/tb_pid_balance_gen2.sv
// Directed bench for pid_balance_gen2: vector table in RUN plus ramp, rider-off,
// over-speed fault and mid-stream reset sequences.
module tb_pid_balance_gen2;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat;
    int   cnt;

    pid_balance_gen2_if #(.OUT_W(11)) bus ();

    pid_balance_gen2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] ptch;
        logic [7:0]         p;
        logic [7:0]         d;
        logic [11:0]        md;
        logic signed [11:0] ld;
        logic               st;
        int                 lspd;
        logic               lrev;
        int                 rspd;
        logic               rrev;
        logic               tf;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Assumes one step has already passed since the vld edge.
    task automatic wait_out(output int l);
        l = 1;
        while (!bus.out_vld && l < 10) begin
            step();
            l++;
        end
    endtask

    task automatic pulse_and_wait(output int l);
        bus.vld = 1'b1;
        step();
        bus.vld = 1'b0;
        wait_out(l);
    endtask

    task automatic ramp_up(input string tag);
        bus.ptch = '0;
        for (int i = 0; i < 64; i++) begin
            bus.vld = 1'b1;
            step();
            if (i == 62) chk({tag, "_still_ramp"}, int'(bus.state), 1);
        end
        bus.vld = 1'b0;
        chk({tag, "_run"}, int'(bus.state), 2);
        repeat (4) step();
        chk({tag, "_spd0"}, int'(bus.lft_spd) + int'(bus.rght_spd), 0);
    endtask

    initial begin
        vecs[0]  = '{16'sd5,     8'd14,  8'd0, 12'd980,  12'sd0,    1'b0, 1050, 1'b0, 1050, 1'b0, 1'b0};
        vecs[1]  = '{-16'sd2,    8'd14,  8'd0, 12'd980,  12'sd0,    1'b0, 420,  1'b1, 420,  1'b1, 1'b0};
        vecs[2]  = '{16'sd10,    8'd20,  8'd0, 12'd980,  12'sd80,   1'b1, 1170, 1'b0, 1190, 1'b0, 1'b0};
        vecs[3]  = '{16'sd0,     8'd0,   8'd0, 12'd980,  12'sd0,    1'b0, 0,    1'b0, 0,    1'b0, 1'b0};
        vecs[4]  = '{16'sd4,     8'd0,   8'd3, 12'd100,  12'sd0,    1'b0, 270,  1'b1, 270,  1'b1, 1'b0};
        vecs[5]  = '{16'sd200,   8'd0,   8'd2, 12'd100,  12'sd0,    1'b0, 229,  1'b0, 229,  1'b0, 1'b0};
        vecs[6]  = '{-16'sd100,  8'd1,   8'd0, 12'd50,   12'sd0,    1'b0, 149,  1'b1, 149,  1'b1, 1'b0};
        vecs[7]  = '{-16'sd3,    8'd10,  8'd0, 12'd0,    -12'sd800, 1'b1, 71,   1'b0, 129,  1'b1, 1'b0};
        vecs[8]  = '{16'sd300,   8'd100, 8'd0, 12'd4000, 12'sd0,    1'b0, 2047, 1'b0, 2047, 1'b0, 1'b1};
        vecs[9]  = '{-16'sd7,    8'd8,   8'd0, 12'd0,    12'sd0,    1'b0, 750,  1'b1, 750,  1'b1, 1'b0};
        vecs[10] = '{16'sd7,     8'd9,   8'd0, 12'd500,  12'sd0,    1'b0, 1035, 1'b0, 1035, 1'b0, 1'b0};
        vecs[11] = '{-16'sd1000, 8'd1,   8'd0, 12'd0,    12'sd0,    1'b0, 514,  1'b1, 514,  1'b1, 1'b0};

        bus.vld = 1'b0; bus.ptch = '0; bus.ld_cell_diff = '0; bus.rider_off = 1'b0;
        bus.en_steer = 1'b0; bus.pwr_up = 1'b1; bus.p_coeff = '0; bus.d_coeff = '0;
        bus.min_duty = '0;
        step();
        step();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_out_vld", int'(bus.out_vld), 0);
        chk("rst_spd", int'(bus.lft_spd) + int'(bus.rght_spd), 0);
        chk("rst_flags", int'(bus.fault) + int'(bus.too_fast), 0);

        rst_n = 1'b1;
        step();
        chk("ramp_entry", int'(bus.state), 1);
        ramp_up("ramp1");

        foreach (vecs[i]) begin
            bus.ptch = vecs[i].ptch; bus.p_coeff = vecs[i].p; bus.d_coeff = vecs[i].d;
            bus.min_duty = vecs[i].md; bus.ld_cell_diff = vecs[i].ld; bus.en_steer = vecs[i].st;
            pulse_and_wait(lat);
            chk($sformatf("vec%0d_latency", i), lat, 3);
            chk($sformatf("vec%0d_lspd", i), int'(bus.lft_spd), vecs[i].lspd);
            chk($sformatf("vec%0d_lrev", i), int'(bus.lft_rev), int'(vecs[i].lrev));
            chk($sformatf("vec%0d_rspd", i), int'(bus.rght_spd), vecs[i].rspd);
            chk($sformatf("vec%0d_rrev", i), int'(bus.rght_rev), int'(vecs[i].rrev));
            chk($sformatf("vec%0d_too_fast", i), int'(bus.too_fast), int'(vecs[i].tf));
        end

        // Rider steps off together with a sample that would otherwise drive 1050.
        bus.ptch = 16'sd5; bus.p_coeff = 8'd14; bus.d_coeff = 8'd0; bus.min_duty = 12'd980;
        bus.ld_cell_diff = '0; bus.en_steer = 1'b0; bus.rider_off = 1'b1; bus.vld = 1'b1;
        step();
        bus.vld = 1'b0;
        chk("rider_off_idle", int'(bus.state), 0);
        wait_out(lat);
        chk("rider_off_latency", lat, 3);
        chk("rider_off_spd", int'(bus.lft_spd) + int'(bus.rght_spd), 0);
        chk("rider_off_rev", int'(bus.lft_rev) + int'(bus.rght_rev), 0);
        bus.rider_off = 1'b0;
        step();
        chk("reentry_ramp", int'(bus.state), 1);
        ramp_up("ramp2");

        // Saturated pitch held: clamp, over-speed, then latched fault.
        bus.ptch = 16'sh7FFF; bus.p_coeff = 8'd255; bus.min_duty = 12'd980; bus.vld = 1'b1;
        step();
        wait_out(lat);
        chk("sat_latency", lat, 3);
        chk("sat_lspd", int'(bus.lft_spd), 2047);
        chk("sat_rspd", int'(bus.rght_spd), 2047);
        chk("sat_rev", int'(bus.lft_rev), 0);
        chk("sat_too_fast", int'(bus.too_fast), 1);
        repeat (3) step();
        chk("fourth_too_fast", int'(bus.too_fast), 1);
        step();
        chk("pre_fault_state", int'(bus.state), 2);
        step();
        chk("fault_state", int'(bus.state), 3);
        chk("fault_flag", int'(bus.fault), 1);
        repeat (3) step();
        chk("fault_spd", int'(bus.lft_spd) + int'(bus.rght_spd), 0);
        chk("fault_too_fast", int'(bus.too_fast), 0);
        repeat (10) step();
        chk("fault_hold", int'(bus.state), 3);
        bus.vld = 1'b0;
        bus.pwr_up = 1'b0;
        step();
        chk("pwr_off_idle", int'(bus.state), 0);
        chk("pwr_off_fault", int'(bus.fault), 0);
        bus.pwr_up = 1'b1;
        step();
        chk("pwr_on_ramp", int'(bus.state), 1);

        // Reset lands while a sample is in flight; it must be discarded.
        bus.ptch = '0;
        bus.vld = 1'b1;
        step();
        bus.vld = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mid_rst_out_vld", int'(bus.out_vld), 0);
        chk("mid_rst_state", int'(bus.state), 0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            step();
            cnt += int'(bus.out_vld);
        end
        chk("post_rst_no_out", cnt, 0);
        pulse_and_wait(lat);
        chk("post_rst_latency", lat, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pid_balance_gen2.md
PID_BALANCE_GEN2 -- requirements
Module: pid_balance_gen2

Interface
REQ-001 Parameter ERR_W, default 10: width of the saturated signed pitch error.
REQ-002 Parameter D_DEPTH, default 2 (legal 1..8): the derivative is taken against the error D_DEPTH valid samples ago.
REQ-003 Parameter I_SHIFT, default 6: arithmetic right shift applied to the integrator before summing.
REQ-004 Parameter OUT_W, default 11: width of the unsigned motor speed.
REQ-005 Parameter RAMP_LOG2, default 6: the soft-start ramp lasts 2^RAMP_LOG2 valid samples.
REQ-006 Parameter LOW_BAND, default 70: torque magnitude below which gain shaping applies.
REQ-007 Parameter GAIN_MULT, default 15: multiplier applied to torque inside the low band.
REQ-008 Parameter FAST_LIM, default 1536: speed threshold for too_fast.
REQ-009 Parameter FAULT_CNT, default 4: number of consecutive too_fast outputs that latches a fault.
REQ-010 clk  in  1  clock; all state updates on the rising edge.
REQ-011 rst_n  in  1  reset, asynchronous, active-low.
REQ-012 vld  in  1  one-cycle strobe marking a new ptch sample; may assert every cycle.
REQ-013 ptch  in  16  signed measured pitch.
REQ-014 ld_cell_diff  in  12  signed left-minus-right load difference.
REQ-015 rider_off, en_steer, pwr_up  in  1 each  rider absent / steering enable / motor enable.
REQ-016 p_coeff, d_coeff  in  8 each  unsigned runtime P and D gains, sampled on vld.
REQ-017 min_duty  in  12  unsigned dead-zone offset, sampled on vld.
REQ-018 lft_spd, rght_spd  out  OUT_W each  unsigned motor speeds.
REQ-019 lft_rev, rght_rev  out  1 each  direction (1 = reverse).
REQ-020 out_vld  out  1  one-cycle strobe marking new speed outputs.
REQ-021 too_fast, fault  out  1 each  speed over limit / latched fault.
REQ-022 state  out  2  FSM state: IDLE=0, RAMP=1, RUN=2, FAULT=3.

Function
REQ-023 The error SHALL be ptch saturated to ERR_W signed bits (clamp to the max/min representable value).
REQ-024 P SHALL be error × signed({0,p_coeff}), computed at full width with no truncation.
REQ-025 A D_DEPTH-entry error history SHALL shift only on vld and SHALL be cleared to 0 while in IDLE.
REQ-026 The D difference (error − oldest history entry) SHALL be saturated to ERR_W−3 signed bits, then multiplied by {0,d_coeff}.
REQ-027 The integrator SHALL be ERR_W+8 bits signed and SHALL add the error on vld in RAMP/RUN only.
REQ-028 The integrator SHALL hold (not wrap) when the add would overflow, and SHALL be cleared in IDLE and FAULT.
REQ-029 The PID sum SHALL be P + D + (I>>>I_SHIFT), saturated to 16-bit signed.
REQ-030 In RAMP, the sum SHALL be scaled to (sum × ramp_cnt) >>> RAMP_LOG2, with ramp_cnt cleared on RAMP entry and incremented per vld.
REQ-031 With en_steer=1: lft torque = sum − (ld_cell_diff>>>3) and rght torque = sum + (ld_cell_diff>>>3), each saturated to 16 bits; with en_steer=0 both equal sum.
REQ-032 Shaping: if |t| ≥ LOW_BAND then t ± min_duty (sign-matched); otherwise t × GAIN_MULT; the result is saturated to 16 bits.
REQ-033 The direction output SHALL be the sign of the shaped value; the speed SHALL be its magnitude, clamped to 2^OUT_W−1.
REQ-034 Pipeline: stage 1 (error, P, D, I) registers on vld; stage 2 registers the sum, ramp and steer; stage 3 registers shaping and outputs. out_vld SHALL assert exactly 3 cycles after vld, with no stall.
REQ-035 Speeds SHALL be forced to 0 and rev bits to 0 on any out_vld while state is IDLE or FAULT; outputs hold between out_vld strobes.
REQ-036 too_fast SHALL be registered with the outputs and SHALL equal (lft_spd > FAST_LIM) | (rght_spd > FAST_LIM).
REQ-037 A fault counter SHALL increment on each out_vld with too_fast=1, clear on out_vld with too_fast=0, and clear outside RUN/RAMP.
REQ-038 FSM transitions, evaluated every cycle in this priority:
- any state, pwr_up=0 → IDLE;
- RAMP/RUN with fault counter = FAULT_CNT → FAULT;
- RAMP/RUN with rider_off=1 → IDLE;
- IDLE with pwr_up=1 and rider_off=0 → RAMP;
- RAMP with ramp_cnt = 2^RAMP_LOG2−1 on vld → RUN.
REQ-039 fault SHALL be 1 only in FAULT; FAULT SHALL be exited only via pwr_up=0.
REQ-040 Samples already in the pipeline when the state changes SHALL complete, subject to the masking in REQ-035 as evaluated at stage 3.

Reset
REQ-041 On rst_n=0, all registers SHALL clear within the same cycle: state=IDLE, all outputs 0, integrator, history, ramp_cnt and fault counter 0.
REQ-042 Deasserting rst_n mid-stream SHALL produce no out_vld until 3 cycles after the first vld following release.

Verification
REQ-043 Defaults, pwr_up=1, rider_off=0, 64 vld with ptch=0 → state RAMP→RUN after the 64th vld, speeds 0; out_vld exactly 3 cycles after each vld.
REQ-044 RUN, p=14, d=0, I cleared, ptch=5 → torque 70 ≥ LOW_BAND; with min_duty=980, spd=1050 and rev=0.
REQ-045 RUN, p=14, ptch=−2 (torque −28) → t×15 = −420, spd=420, rev=1.
REQ-046 ptch=0x7FFF held → error saturates to 511, integrator stops below +2^17 without wrapping, spd clamps at 2047, too_fast=1; after 4 out_vld, fault=1 and state=3; spd forced to 0 until pwr_up toggles.
REQ-047 rider_off asserted mid-RUN → IDLE next cycle, integrator 0, the next out_vld shows spd 0.
REQ-048 en_steer=1, sum 200, ld_cell_diff=+80 → lft torque 190 and rght torque 210, both shaped with +min_duty.
